// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline controller FSM state.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    DWAIT,
    DRAIN,
    HALTED
  } pctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the EX-stage load and the ID-stage sources.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_MemToReg,
  input  regbits_t idex_writeReg,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     lu
);

  // $zero is never a real dependency.
  always_comb begin
    lu = idex_MemToReg && (idex_writeReg != '0) &&
         ((idex_writeReg == ifid_rs) || (idex_writeReg == ifid_rt));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing controller: latch enables and flushes, halt FSM and
// saturating stall/flush counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_branch_taken,
  input  logic             id_jump,
  input  logic             idex_MemToReg,
  input  regbits_t         idex_writeReg,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             mem_halt,
  input  logic             wb_halt,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             idex_wen,
  output logic             exmem_wen,
  output logic             memwb_wen,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pctrl_state_t state, next_state;
  logic         dstall;
  logic         lu;
  logic         stall_evt;
  logic         flush_evt;

  hazard_detect u_hazard_detect (
    .idex_MemToReg (idex_MemToReg),
    .idex_writeReg (idex_writeReg),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .lu            (lu)
  );

  assign dstall = (mem_dREN | mem_dWEN) & ~dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // DWAIT is left in the dhit cycle, which is then treated exactly like RUN.
  always_comb begin
    next_state = state;
    unique case (state)
      RUN, DWAIT: begin
        if (dstall)        next_state = DWAIT;
        else if (mem_halt) next_state = DRAIN;
        else               next_state = RUN;
      end
      DRAIN: begin
        if (dstall)       next_state = DWAIT;
        else if (wb_halt) next_state = HALTED;
      end
      HALTED:  next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    pc_wen      = ihit;
    ifid_wen    = 1'b1;
    idex_wen    = 1'b1;
    exmem_wen   = 1'b1;
    memwb_wen   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    halted      = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;
    if (state == HALTED) begin
      pc_wen    = 1'b0;
      ifid_wen  = 1'b0;
      idex_wen  = 1'b0;
      exmem_wen = 1'b0;
      memwb_wen = 1'b0;
      halted    = 1'b1;
    end else if (dstall) begin
      // Freeze everything up to EX/MEM and push a bubble into WB.
      pc_wen      = 1'b0;
      ifid_wen    = 1'b0;
      idex_wen    = 1'b0;
      exmem_wen   = 1'b0;
      memwb_flush = 1'b1;
      stall_evt   = 1'b1;
    end else if ((state == DRAIN) || mem_halt) begin
      pc_wen      = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (mem_branch_taken) begin
      pc_wen      = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_evt   = 1'b1;
    end else if (lu) begin
      pc_wen     = 1'b0;
      ifid_wen   = 1'b0;
      idex_flush = 1'b1;
    end else if (id_jump) begin
      pc_wen     = 1'b1;
      ifid_flush = 1'b1;
      flush_evt  = 1'b1;
    end else if (!ihit) begin
      pc_wen     = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
